// File: rtl/frame_scanout.sv
// frame_scanout: scan-out side of a double-buffered 1-bpp framebuffer.
// Generates raster timing, reads the front bank in raster order and emits
// video aligned to the memory read latency. It also hands the back buffer
// over to the renderer once per frame, at the start of vertical blanking.
//
// Ports:
//   clk      in   pixel clock
//   rst      in   synchronous active-high reset
//   wr_done  in   renderer finished the back buffer
//   rd_en    out  framebuffer read strobe
//   rd_addr  out  pixel address y*HOR_ACTIVE_PIXELS + x (bank not included)
//   rd_data  in   pixel read back, RD_LATENCY cycles after rd_en
//   front    out  bank being scanned out; renderer owns ~front
//   swap     out  one-cycle handover pulse to the renderer
//   hsync    out  horizontal sync, polarity set by SYNC_ACTIVE_HIGH
//   vsync    out  vertical sync, polarity set by SYNC_ACTIVE_HIGH
//   de       out  data enable
//   pixel    out  pixel value, forced to 0 outside the active region
module frame_scanout #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned HOR_FRONT_PORCH   = 16,
    parameter int unsigned HOR_SYNC_PULSE    = 96,
    parameter int unsigned HOR_BACK_PORCH    = 48,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned VER_FRONT_PORCH   = 10,
    parameter int unsigned VER_SYNC_PULSE    = 2,
    parameter int unsigned VER_BACK_PORCH    = 33,
    parameter int unsigned SYNC_ACTIVE_HIGH  = 0,
    parameter int unsigned RD_LATENCY        = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_done,
    output logic rd_en,
    output logic [$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)-1:0] rd_addr,
    input  logic rd_data,
    output logic front,
    output logic swap,
    output logic hsync,
    output logic vsync,
    output logic de,
    output logic pixel
);

    localparam int unsigned H_TOTAL  = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH
                                     + HOR_SYNC_PULSE + HOR_BACK_PORCH;
    localparam int unsigned V_TOTAL  = VER_ACTIVE_PIXELS + VER_FRONT_PORCH
                                     + VER_SYNC_PULSE + VER_BACK_PORCH;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned AW       = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS);
    localparam int unsigned HS_START = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int unsigned HS_END   = HS_START + HOR_SYNC_PULSE;
    localparam int unsigned VS_START = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int unsigned VS_END   = VS_START + VER_SYNC_PULSE;
    localparam int unsigned LAST     = RD_LATENCY - 1;

    // Pipeline word bit positions
    localparam int unsigned P_ACT = 2;
    localparam int unsigned P_HS  = 1;
    localparam int unsigned P_VS  = 0;

    // XOR mask turning an internal active-high sync into the output level
    localparam logic SYNC_INV = (SYNC_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_en_q;
    logic          hs1_q, vs1_q;
    logic [2:0]    pipe_q [RD_LATENCY];
    logic          de_q, pixel_q, hsync_q, vsync_q;
    logic          swap_q, swap_d;
    logic          front_q, front_d;

    logic          active_c, hs_c, vs_c, trig_c, frame_start_c;
    logic [2:0]    pipe_out_c;

    // Raster counters: h wraps every line, v advances on the h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (32'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            if (32'(v_cnt_q) == V_TOTAL - 1) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end
    end

    // Stage-0 decode of the counters
    always_comb begin
        active_c      = (32'(h_cnt_q) < HOR_ACTIVE_PIXELS)
                     && (32'(v_cnt_q) < VER_ACTIVE_PIXELS);
        hs_c          = (32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END);
        vs_c          = (32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END);
        frame_start_c = (h_cnt_q == '0) && (v_cnt_q == '0);
        trig_c        = (h_cnt_q == '0) && (32'(v_cnt_q) == VER_ACTIVE_PIXELS);
    end

    // Running pixel address: advances after each issued read, no multiply
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (frame_start_c) begin
            rd_addr_d = '0;
        end else if (rd_en_q) begin
            rd_addr_d = rd_addr_q + AW'(1);
        end
    end

    // Buffer handover only on the first blanking line, and only if ready
    always_comb begin
        swap_d  = trig_c & wr_done;
        front_d = front_q ^ swap_d;
    end

    assign pipe_out_c = pipe_q[LAST];

    // Counter, address and handover registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            swap_q    <= 1'b0;
            front_q   <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= active_c;
            hs1_q     <= hs_c;
            vs1_q     <= vs_c;
            swap_q    <= swap_d;
            front_q   <= front_d;
        end
    end

    // Delay timing by the read latency so it lines up with rd_data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {rd_en_q, hs1_q, vs1_q};
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Output stage: video signals registered together, pixel masked by de
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q    <= 1'b0;
            pixel_q <= 1'b0;
            hsync_q <= SYNC_INV;
            vsync_q <= SYNC_INV;
        end else begin
            de_q    <= pipe_out_c[P_ACT];
            pixel_q <= rd_data & pipe_out_c[P_ACT];
            hsync_q <= pipe_out_c[P_HS] ^ SYNC_INV;
            vsync_q <= pipe_out_c[P_VS] ^ SYNC_INV;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign front   = front_q;
    assign swap    = swap_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign de      = de_q;
    assign pixel   = pixel_q;

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: directed bench for frame_scanout on a tiny 8x4 raster
// (H 8/1/2/1, V 4/1/1/1, active-low sync) with RD_LATENCY 1 and 3 instances
// running side by side. Each instance reads a model RAM returning addr[0].
module tb_frame_scanout;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_done = 1'b1;

    logic       rd_en1, rd_data1, front1, swap1, hsync1, vsync1, de1, pixel1;
    logic [4:0] rd_addr1;
    logic       rd_en3, rd_data3, front3, swap3, hsync3, vsync3, de3, pixel3;
    logic [4:0] rd_addr3;
    logic [2:0] ram3_q = 3'b000;

    int n_checks = 0;
    int n_err    = 0;
    int swap_obs = 0;
    int rden_cnt = 0;
    bit front_exp = 1'b0;

    always #5 clk = ~clk;

    frame_scanout #(
        .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(1), .HOR_SYNC_PULSE(2), .HOR_BACK_PORCH(1),
        .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(1), .VER_SYNC_PULSE(1), .VER_BACK_PORCH(1),
        .SYNC_ACTIVE_HIGH(0), .RD_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .wr_done(wr_done), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .front(front1), .swap(swap1), .hsync(hsync1),
        .vsync(vsync1), .de(de1), .pixel(pixel1)
    );

    frame_scanout #(
        .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(1), .HOR_SYNC_PULSE(2), .HOR_BACK_PORCH(1),
        .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(1), .VER_SYNC_PULSE(1), .VER_BACK_PORCH(1),
        .SYNC_ACTIVE_HIGH(0), .RD_LATENCY(3)
    ) u_dut3 (
        .clk(clk), .rst(rst), .wr_done(wr_done), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .rd_data(rd_data3), .front(front3), .swap(swap3), .hsync(hsync3),
        .vsync(vsync3), .de(de3), .pixel(pixel3)
    );

    // Model RAMs: content is addr[0], returned after 1 and 3 cycles
    always @(posedge clk) begin
        rd_data1 <= rd_addr1[0];
        ram3_q   <= {ram3_q[1:0], rd_addr3[0]};
    end
    assign rd_data3 = ram3_q[2];

    // Raster geometry for interval j after reset release (12 x 7 raster)
    function automatic int h_at(input int j);
        return j % 12;
    endfunction

    function automatic int v_at(input int j);
        return (j / 12) % 7;
    endfunction

    function automatic int act_at(input int j);
        if (j < 0) return 0;
        return (h_at(j) < 8 && v_at(j) < 4) ? 1 : 0;
    endfunction

    function automatic int hs_at(input int j);
        if (j < 0) return 0;
        return (h_at(j) == 9 || h_at(j) == 10) ? 1 : 0;
    endfunction

    function automatic int vs_at(input int j);
        if (j < 0) return 0;
        return (v_at(j) == 5) ? 1 : 0;
    endfunction

    function automatic int trig_at(input int j);
        if (j < 0) return 0;
        return (h_at(j) == 0 && v_at(j) == 4) ? 1 : 0;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_dut(input string nm, input int k, input int lat,
                             input logic en, input logic [4:0] addr, input logic d,
                             input logic hs, input logic vs, input logic px,
                             input logic sw, input logic fr, input int sw_exp);
        int j;
        j = k - lat - 2;
        check_val($sformatf("%s.rd_en@%0d", nm, k), 32'(en), act_at(k - 1));
        if (act_at(k - 1) != 0)
            check_val($sformatf("%s.rd_addr@%0d", nm, k), 32'(addr),
                      v_at(k - 1) * 8 + h_at(k - 1));
        check_val($sformatf("%s.de@%0d", nm, k), 32'(d), act_at(j));
        check_val($sformatf("%s.hsync@%0d", nm, k), 32'(hs), 1 - hs_at(j));
        check_val($sformatf("%s.vsync@%0d", nm, k), 32'(vs), 1 - vs_at(j));
        check_val($sformatf("%s.pixel@%0d", nm, k), 32'(px),
                  (act_at(j) != 0) ? (h_at(j) % 2) : 0);
        check_val($sformatf("%s.swap@%0d", nm, k), 32'(sw), sw_exp);
        check_val($sformatf("%s.front@%0d", nm, k), 32'(fr), 32'(front_exp));
    endtask

    task automatic check_reset_vals(input string nm, input logic en, input logic [4:0] addr,
                                    input logic d, input logic hs, input logic vs,
                                    input logic px, input logic sw, input logic fr);
        check_val({nm, ".rst_rd_en"}, 32'(en), 0);
        check_val({nm, ".rst_rd_addr"}, 32'(addr), 0);
        check_val({nm, ".rst_de"}, 32'(d), 0);
        check_val({nm, ".rst_hsync"}, 32'(hs), 1);
        check_val({nm, ".rst_vsync"}, 32'(vs), 1);
        check_val({nm, ".rst_pixel"}, 32'(px), 0);
        check_val({nm, ".rst_swap"}, 32'(sw), 0);
        check_val({nm, ".rst_front"}, 32'(fr), 0);
    endtask

    // Apply one reset edge at a negedge, check reset state, release rst
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("L1", rd_en1, rd_addr1, de1, hsync1, vsync1, pixel1, swap1, front1);
        check_reset_vals("L3", rd_en3, rd_addr3, de3, hsync3, vsync3, pixel3, swap3, front3);
        front_exp = 1'b0;
        rst = 1'b0;
    endtask

    // Run n intervals from reset release; phase 1 withholds wr_done at the first vblank
    task automatic run(input int n, input int phase);
        int trig_last;
        int wd_last;
        int sw_exp;
        trig_last = 0;
        wd_last   = 0;
        for (int k = 0; k < n; k++) begin
            sw_exp = (trig_last != 0 && wd_last != 0) ? 1 : 0;
            if (sw_exp != 0) front_exp = ~front_exp;
            check_dut("L1", k, 1, rd_en1, rd_addr1, de1, hsync1, vsync1, pixel1,
                      swap1, front1, sw_exp);
            check_dut("L3", k, 3, rd_en3, rd_addr3, de3, hsync3, vsync3, pixel3,
                      swap3, front3, sw_exp);
            if (k >= 1 && k <= 84 && rd_en1) rden_cnt++;
            if (swap1) swap_obs++;
            if (phase == 1) wr_done = (k == 47 || k == 49 || k >= 60);
            else            wr_done = 1'b1;
            trig_last = trig_at(k);
            wd_last   = wr_done ? 1 : 0;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);

        // Three full frames with the renderer always ready
        do_reset();
        swap_obs = 0;
        rden_cnt = 0;
        run(260, 0);
        check_val("A.rd_en_per_frame", rden_cnt, 32);
        check_val("A.swap_count", swap_obs, 3);
        check_val("A.front_final", 32'(front1), 1);

        // Renderer not ready at the first vblank, ready mid-frame afterwards
        do_reset();
        swap_obs = 0;
        run(180, 1);
        check_val("B.swap_count", swap_obs, 1);
        check_val("B.front_final", 32'(front1), 1);

        // Reset lands at (h=5, v=2) of the second frame, then a clean restart
        do_reset();
        run(113, 0);
        do_reset();
        run(90, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_scanout.md
# frame_scanout

Read side of the 1-bpp framebuffer that `frame_renderer` writes. It generates VGA/HDMI video timing and reads the front buffer pixel-by-pixel in raster order. It outputs `hsync`/`vsync`/`de`/`pixel` aligned to the memory read latency. Once per frame, at the start of vertical blanking, it issues the single-cycle `swap` pulse that releases the renderer and flips the front/back buffer select.

## Interface

Parameters:

- `HOR_ACTIVE_PIXELS`, 640, visible pixels per line
- `HOR_FRONT_PORCH`, 16, pixels
- `HOR_SYNC_PULSE`, 96, pixels
- `HOR_BACK_PORCH`, 48, pixels
- `VER_ACTIVE_PIXELS`, 480, visible lines
- `VER_FRONT_PORCH`, 10, lines
- `VER_SYNC_PULSE`, 2, lines
- `VER_BACK_PORCH`, 33, lines
- `SYNC_ACTIVE_HIGH`, 0, 0 means sync pulses are driven low
- `RD_LATENCY`, 1, clk cycles from `rd_en`/`rd_addr` to valid `rd_data`; must be 1..4

Ports:

- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `wr_done`  in  1  renderer has finished the back buffer; tie to 1 if unused
- `rd_en`  out  1  framebuffer read strobe
- `rd_addr`  out  `$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)`  pixel address, y*HOR_ACTIVE_PIXELS + x
- `rd_data`  in  1  pixel read back, valid `RD_LATENCY` cycles after `rd_en`
- `front`  out  1  bank currently scanned out; the renderer writes bank `~front`
- `swap`  out  1  one-cycle pulse to the renderer
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `de`  out  1  data enable (active region)
- `pixel`  out  1  pixel value; 0 whenever `de`=0

## Operation

- Derived totals: H_TOTAL = sum of the four horizontal parameters; V_TOTAL = sum of the four vertical parameters.
- Counters, stage 0:
  - `h_cnt` runs 0..H_TOTAL-1 every clk and wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps and itself wraps from V_TOTAL-1 to 0.
- Stage-0 signals:
  - active = `h_cnt` < HOR_ACTIVE_PIXELS && `v_cnt` < VER_ACTIVE_PIXELS.
  - hs = `h_cnt` in [HOR_ACTIVE_PIXELS+HOR_FRONT_PORCH, HOR_ACTIVE_PIXELS+HOR_FRONT_PORCH+HOR_SYNC_PULSE).
  - vs is the same window on `v_cnt` using the vertical parameters.
- Read address generation:
  - `rd_en` = registered active.
  - `rd_addr` is a running counter: it increments by 1 after each active read and resets to 0 when `h_cnt`==0 && `v_cnt`==0.
  - No multiplier is used. The last active read uses address H*V-1.
- Delay pipeline:
  - active, hs and vs are delayed RD_LATENCY further cycles through a shift register.
  - The final stage registers `de`, `hsync`, `vsync` and `pixel` = `rd_data` & delayed active.
  - Sync outputs are driven at polarity `SYNC_ACTIVE_HIGH`.
- Swap:
  - The trigger cycle is the one where `h_cnt`==0 && `v_cnt`==VER_ACTIVE_PIXELS (first blanking line).
  - If `wr_done` is high on the trigger cycle, `swap` is 1 for exactly the following cycle and `front` toggles on that same edge.
  - If `wr_done` is low, there is no pulse and no toggle; the old front buffer is shown again.
  - At most one swap per frame.
- `rd_addr` does not carry the bank bit. Bank steering is external using `front`, and `front` changes only during vertical blanking, so a frame is never torn.

## Timing

- Reset values:
  - `h_cnt`=`v_cnt`=0, `rd_addr`=0, `rd_en`=0, `front`=0, `swap`=0, `de`=0, `pixel`=0.
  - `hsync`/`vsync` at the inactive level.
  - All delay-pipeline stages cleared.
- Reset mid-frame:
  - All of the above apply on the next edge.
  - The first cycle after `rst` drops has `h_cnt`=0, `v_cnt`=0.
  - `rd_en` rises 1 cycle later.
  - `de` rises RD_LATENCY+2 cycles after `rst` deasserts.
- Latency: `rd_en`/`rd_addr` lag the counters by 1 cycle; `de`/`hsync`/`vsync`/`pixel` lag the counters by RD_LATENCY+2 cycles.
- Relative alignment: `hsync`, `vsync` and `de` keep exact relative timing to each other.
- `pixel` for address A appears in the same cycle `de` marks pixel A.
- `swap` is a single-cycle pulse. It is not delayed by the pipeline and is referenced to the counters.
- Simultaneous events:
  - The `h_cnt` wrap and the `v_cnt` wrap on the same edge put the counters at (0,0) and reset `rd_addr` in the same cycle.
  - `wr_done` toggling on any cycle other than the trigger cycle has no effect.

## Test plan

Bench parameters: H = 8/1/2/1 (H_TOTAL 12), V = 4/1/1/1 (V_TOTAL 7), RD_LATENCY 1, with a model RAM seeded with pattern addr[0].

1. **Reset then run one frame.**
   - `rd_en` high 32 cycles per frame, in 4 runs of 8 consecutive cycles.
   - `rd_addr` goes 0..31.
   - `de` is the same waveform delayed 2 cycles.
   - `pixel` = 0,1,0,1… during `de`, and 0 elsewhere.
2. **Sync windows.**
   - `hsync` low exactly at `h_cnt` 9..10 (delayed 3 cycles from the counters).
   - `vsync` low for 12 cycles on line 5.
   - Both stay high otherwise.
3. **Swap with `wr_done`=1.**
   - One `swap` pulse per frame, 1 cycle after (`h_cnt`=0,`v_cnt`=4).
   - `front` toggles on that same edge.
   - 3 frames give `front` sequence 0→1→0→1.
4. **Swap withheld.**
   - `wr_done`=0 on the trigger cycle: no `swap`, `front` unchanged.
   - `wr_done` raised mid-frame: the swap occurs at the next vblank only.
5. **Reset mid-line at (`h_cnt`=5,`v_cnt`=2).**
   - All outputs return to their reset values.
   - The next frame starts at `rd_addr` 0 with correct `de` alignment.
6. **RD_LATENCY=3 variant.**
   - `de`/`pixel`/`hsync` lag the counters by 5 cycles.
   - `pixel` still matches addr[0] per pixel.
